// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer:
// FSM states, register map, LED target addresses, field positions.
package led_pattern_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD1,
        S_LOAD2,
        S_DWELL,
        S_NEXT
    } seq_state_t;

    // Word indices (byte address >> 2)
    localparam logic [5:0] W_CTRL   = 6'h00;
    localparam logic [5:0] W_STATUS = 6'h01;
    // Table banks live at word[5:4]: 01 = COLOR, 10 = DWELL
    localparam logic [1:0] B_COLOR  = 2'b01;
    localparam logic [1:0] B_DWELL  = 2'b10;

    localparam logic [7:0] LED_ADDR_STATE1 = 8'h04;
    localparam logic [7:0] LED_ADDR_STATE2 = 8'h08;

    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int CTRL_LOOP    = 2;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_LAST_LO = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_CUR_LO  = 4;
    localparam int STAT_DONE    = 8;

    function automatic logic [3:0] clamp_step(
        input logic [3:0] s,
        input logic [3:0] max_s
    );
        return (s > max_s) ? max_s : s;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// CPU register bus and LED peripheral write port.
// The sequencer is a slave on the CPU bus and a master on the LED port.
interface led_seq_bus_if;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;

    modport master (
        output bus_write_en, bus_read_en, bus_addr, bus_write_data,
        input  bus_read_data
    );
    modport slave (
        input  bus_write_en, bus_read_en, bus_addr, bus_write_data,
        output bus_read_data
    );
endinterface

interface led_seq_led_if;
    logic        led_write_en;
    logic [7:0]  led_addr;
    logic [31:0] led_write_data;

    modport master (
        output led_write_en, led_addr, led_write_data
    );
    modport slave (
        input  led_write_en, led_addr, led_write_data
    );
endinterface

// File: rtl/led_seq_tick_prescaler.sv
// Dwell-time prescaler: counts 0..TICK_DIV-1 and pulses tick
// for one cycle on the terminal count; clr restarts from 0.
module led_seq_tick_prescaler #(
    parameter int TICK_DIV = 100000
) (
    input  logic pclk,
    input  logic nreset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TOP);

    // Free-running divider, restarted synchronously by clr
    always_ff @(posedge pclk) begin
        if (!nreset || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: plays a colour/dwell table into rgb_led.
// Optional completion interrupt enabled by defining LED_SEQ_IRQ_EN.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int TICK_DIV  = 100000,
    parameter int DWELL_W   = 16
) (
    input  logic          pclk,
    input  logic          nreset,
    led_seq_bus_if.slave  bus,
    led_seq_led_if.master led,
`ifdef LED_SEQ_IRQ_EN
    output logic          seq_irq,
`endif
    output logic          seq_busy
);
    localparam int IW = $clog2(NUM_STEPS);
    localparam logic [3:0] LAST_MAX = 4'(NUM_STEPS - 1);
    localparam logic [4:0] DEPTH = 5'(NUM_STEPS);

    logic [31:0]        color [NUM_STEPS];
    logic [DWELL_W-1:0] dwell [NUM_STEPS];

    seq_state_t         state;
    logic [3:0]         cur;
    logic [3:0]         last_step;
    logic               loop_en;
    logic               done;
    logic               stop_pend;
    logic [DWELL_W-1:0] tcnt;
`ifdef LED_SEQ_IRQ_EN
    logic               irq_en;
`endif

    logic [5:0]         word;
    logic [31:0]        wd;
    logic               wr, rd;
    logic               ctrl_hit, stat_hit, col_hit, dwl_hit;
    logic [IW-1:0]      tidx;
    logic               start_req, stop_req;
    logic [31:0]        rd_mux;
    logic               tick, pre_clr, expire, at_last;
    logic [DWELL_W-1:0] dmin;
    logic [3:0]         nxt;
    logic [IW-1:0]      cur_i;
    logic               unused_bits;

    assign word = bus.bus_addr[7:2];
    assign wd   = bus.bus_write_data;
    assign wr   = bus.bus_write_en;
    assign rd   = bus.bus_read_en && !bus.bus_write_en;
    assign tidx = word[IW-1:0];
    assign unused_bits = ^bus.bus_addr[1:0];

    assign ctrl_hit = (word == W_CTRL);
    assign stat_hit = (word == W_STATUS);
    assign col_hit  = (word[5:4] == B_COLOR) && ({1'b0, word[3:0]} < DEPTH);
    assign dwl_hit  = (word[5:4] == B_DWELL) && ({1'b0, word[3:0]} < DEPTH);

    assign start_req = wr && ctrl_hit && wd[CTRL_START] && !wd[CTRL_STOP];
    assign stop_req  = wr && ctrl_hit && wd[CTRL_STOP];

    assign cur_i   = cur[IW-1:0];
    assign dmin    = (dwell[cur_i] == '0) ? DWELL_W'(1) : dwell[cur_i];
    assign expire  = tick && (tcnt == dmin - DWELL_W'(1));
    assign at_last = (cur == last_step);
    assign nxt     = at_last ? 4'd0 : cur + 4'd1;
    assign pre_clr = (state != S_DWELL);

`ifdef LED_SEQ_IRQ_EN
    assign seq_irq = done && irq_en;
`endif

    led_seq_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .pclk   (pclk),
        .nreset (nreset),
        .clr    (pre_clr),
        .tick   (tick)
    );

    // Register read decode
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            ctrl_hit: begin
                rd_mux[CTRL_LOOP] = loop_en;
`ifdef LED_SEQ_IRQ_EN
                rd_mux[CTRL_IRQ_EN] = irq_en;
`endif
                rd_mux[CTRL_LAST_LO +: 4] = last_step;
            end
            stat_hit: begin
                rd_mux[STAT_BUSY]       = seq_busy;
                rd_mux[STAT_CUR_LO +: 4] = cur;
                rd_mux[STAT_DONE]       = done;
            end
            col_hit:  rd_mux = color[tidx];
            dwl_hit:  rd_mux[DWELL_W-1:0] = dwell[tidx];
            default:  rd_mux = '0;
        endcase
    end

    // Register file, read port and sequencing FSM
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                color[i] <= '0;
                dwell[i] <= '0;
            end
            state              <= S_IDLE;
            cur                <= '0;
            last_step          <= '0;
            loop_en            <= 1'b0;
            done               <= 1'b0;
            stop_pend          <= 1'b0;
            tcnt               <= '0;
            seq_busy           <= 1'b0;
            bus.bus_read_data  <= '0;
            led.led_write_en   <= 1'b0;
            led.led_addr       <= '0;
            led.led_write_data <= '0;
`ifdef LED_SEQ_IRQ_EN
            irq_en             <= 1'b0;
`endif
        end else begin
            led.led_write_en   <= 1'b0;
            led.led_addr       <= '0;
            led.led_write_data <= '0;

            if (rd) bus.bus_read_data <= rd_mux;

            if (wr && ctrl_hit) begin
                loop_en   <= wd[CTRL_LOOP];
                last_step <= clamp_step(wd[CTRL_LAST_LO +: 4], LAST_MAX);
`ifdef LED_SEQ_IRQ_EN
                irq_en    <= wd[CTRL_IRQ_EN];
`endif
            end
            if (wr && stat_hit && wd[STAT_DONE]) done <= 1'b0;
            if (wr && col_hit) color[tidx] <= wd;
            if (wr && dwl_hit) dwell[tidx] <= wd[DWELL_W-1:0];

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state              <= S_LOAD1;
                        cur                <= '0;
                        stop_pend          <= 1'b0;
                        seq_busy           <= 1'b1;
                        led.led_write_en   <= 1'b1;
                        led.led_addr       <= LED_ADDR_STATE1;
                        led.led_write_data <= color[0];
                    end
                end
                S_LOAD1: begin
                    state              <= S_LOAD2;
                    led.led_write_en   <= 1'b1;
                    led.led_addr       <= LED_ADDR_STATE2;
                    led.led_write_data <= color[cur_i];
                    if (stop_req) stop_pend <= 1'b1;
                end
                S_LOAD2: begin
                    if (stop_req || stop_pend) begin
                        state     <= S_IDLE;
                        stop_pend <= 1'b0;
                        seq_busy  <= 1'b0;
                    end else begin
                        state <= S_DWELL;
                        tcnt  <= '0;
                    end
                end
                S_DWELL: begin
                    if (stop_req) begin
                        state    <= S_IDLE;
                        seq_busy <= 1'b0;
                    end else if (expire) begin
                        state <= S_NEXT;
                    end else if (tick) begin
                        tcnt <= tcnt + DWELL_W'(1);
                    end
                end
                S_NEXT: begin
                    if (stop_req) begin
                        state    <= S_IDLE;
                        seq_busy <= 1'b0;
                    end else if (at_last && !loop_en) begin
                        state    <= S_IDLE;
                        done     <= 1'b1;
                        seq_busy <= 1'b0;
                    end else begin
                        state              <= S_LOAD1;
                        cur                <= nxt;
                        led.led_write_en   <= 1'b1;
                        led.led_addr       <= LED_ADDR_STATE1;
                        led.led_write_data <= color[nxt[IW-1:0]];
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    seq_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
